// File: rtl/ltpi_data_channel_fifo_agent.sv
// Initiator-side agent for the data channel controller FIFO: one host transaction at a time,
// four-phase request write / response read, response timeout and flush of late responses.
module ltpi_data_channel_fifo_agent #(
   parameter int unsigned REQ_WIDTH      = 32,
   parameter int unsigned RESP_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  host_req_valid,
   input  logic [REQ_WIDTH-1:0]  host_req_data,
   output logic                  host_req_ready,
   output logic                  host_resp_valid,
   output logic [RESP_WIDTH-1:0] host_resp_data,
   output logic                  host_resp_status,
   input  logic                  host_resp_ready,
   output logic                  fifo_req_wr_en,
   output logic [REQ_WIDTH-1:0]  fifo_req_wr_data,
   input  logic                  fifo_req_wr_ack,
   input  logic                  fifo_req_full,
   output logic                  fifo_resp_rd_en,
   input  logic [RESP_WIDTH-1:0] fifo_resp_rd_data,
   input  logic                  fifo_resp_rd_ack,
   input  logic                  fifo_resp_empty,
   output logic                  busy,
   output logic [7:0]            drop_count
);

   localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned TW     = (TW_RAW < 1) ? 1 : TW_RAW;
   localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_REQ_WR,
      S_REQ_REL,
      S_RESP_WAIT,
      S_RESP_RD,
      S_RESP_REL,
      S_HOST_RESP,
      S_FLUSH_RD,
      S_FLUSH_REL
   } state_t;

   state_t                state, state_nxt;
   logic [TW-1:0]         timer, timer_nxt;
   logic                  req_ready_nxt;
   logic                  resp_valid_nxt;
   logic [RESP_WIDTH-1:0] resp_data_nxt;
   logic                  resp_status_nxt;
   logic                  wr_en_nxt;
   logic [REQ_WIDTH-1:0]  wr_data_nxt;
   logic                  rd_en_nxt;
   logic                  busy_nxt;
   logic [7:0]            drop_count_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         timer            <= '0;
         host_req_ready   <= 1'b0;
         host_resp_valid  <= 1'b0;
         host_resp_data   <= '0;
         host_resp_status <= 1'b0;
         fifo_req_wr_en   <= 1'b0;
         fifo_req_wr_data <= '0;
         fifo_resp_rd_en  <= 1'b0;
         busy             <= 1'b0;
         drop_count       <= '0;
      end else begin
         state            <= state_nxt;
         timer            <= timer_nxt;
         host_req_ready   <= req_ready_nxt;
         host_resp_valid  <= resp_valid_nxt;
         host_resp_data   <= resp_data_nxt;
         host_resp_status <= resp_status_nxt;
         fifo_req_wr_en   <= wr_en_nxt;
         fifo_req_wr_data <= wr_data_nxt;
         fifo_resp_rd_en  <= rd_en_nxt;
         busy             <= busy_nxt;
         drop_count       <= drop_count_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      timer_nxt       = timer;
      resp_valid_nxt  = host_resp_valid;
      resp_data_nxt   = host_resp_data;
      resp_status_nxt = host_resp_status;
      wr_en_nxt       = fifo_req_wr_en;
      wr_data_nxt     = fifo_req_wr_data;
      rd_en_nxt       = fifo_resp_rd_en;
      drop_count_nxt  = drop_count;

      case (state)
         S_IDLE: begin
            // A stale response must be drained before a new request can be matched to a reply
            if (!fifo_resp_empty) begin
               if (!fifo_resp_rd_ack) begin
                  rd_en_nxt = 1'b1;
                  state_nxt = S_FLUSH_RD;
               end
            end else if (host_req_valid && host_req_ready && !fifo_req_wr_ack) begin
               wr_data_nxt = host_req_data;
               wr_en_nxt   = 1'b1;
               state_nxt   = S_REQ_WR;
            end
         end
         S_REQ_WR: begin
            if (fifo_req_wr_ack) begin
               wr_en_nxt = 1'b0;
               state_nxt = S_REQ_REL;
            end
         end
         S_REQ_REL: begin
            if (!fifo_req_wr_ack) begin
               timer_nxt = '0;
               state_nxt = S_RESP_WAIT;
            end
         end
         S_RESP_WAIT: begin
            if (!fifo_resp_empty) begin
               if (!fifo_resp_rd_ack) begin
                  rd_en_nxt = 1'b1;
                  state_nxt = S_RESP_RD;
               end
            end else begin
               timer_nxt = timer + TW'(1);
               if ((TIMEOUT_CYCLES != 0) && (timer == TLAST)) begin
                  resp_data_nxt   = '0;
                  resp_status_nxt = 1'b1;
                  resp_valid_nxt  = 1'b1;
                  state_nxt       = S_HOST_RESP;
               end
            end
         end
         S_RESP_RD: begin
            if (fifo_resp_rd_ack) begin
               resp_data_nxt = fifo_resp_rd_data;
               rd_en_nxt     = 1'b0;
               state_nxt     = S_RESP_REL;
            end
         end
         S_RESP_REL: begin
            if (!fifo_resp_rd_ack) begin
               resp_status_nxt = 1'b0;
               resp_valid_nxt  = 1'b1;
               state_nxt       = S_HOST_RESP;
            end
         end
         S_HOST_RESP: begin
            if (host_resp_ready) begin
               resp_valid_nxt = 1'b0;
               state_nxt      = S_IDLE;
            end
         end
         S_FLUSH_RD: begin
            if (fifo_resp_rd_ack) begin
               rd_en_nxt = 1'b0;
               state_nxt = S_FLUSH_REL;
            end
         end
         S_FLUSH_REL: begin
            if (!fifo_resp_rd_ack) begin
               if (drop_count != 8'hFF) drop_count_nxt = drop_count + 8'd1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Registered outputs are derived from the next state so they track the state register exactly
      busy_nxt      = (state_nxt != S_IDLE);
      req_ready_nxt = (state_nxt == S_IDLE) && !fifo_req_full && fifo_resp_empty &&
                      !fifo_req_wr_ack && !fifo_resp_rd_ack;
   end

endmodule

// File: tb/tb_ltpi_data_channel_fifo_agent.sv
// Scoreboard bench for ltpi_data_channel_fifo_agent with a behavioural four-phase FIFO model.
module tb_ltpi_data_channel_fifo_agent;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        host_req_valid = 1'b0;
   logic [31:0] host_req_data = '0;
   logic        host_req_ready;
   logic        host_resp_valid;
   logic [31:0] host_resp_data;
   logic        host_resp_status;
   logic        host_resp_ready = 1'b0;
   logic        fifo_req_wr_en;
   logic [31:0] fifo_req_wr_data;
   logic        fifo_req_wr_ack = 1'b0;
   logic        fifo_req_full = 1'b0;
   logic        fifo_resp_rd_en;
   logic [31:0] fifo_resp_rd_data = '0;
   logic        fifo_resp_rd_ack = 1'b0;
   logic        fifo_resp_empty = 1'b1;
   logic        busy;
   logic [7:0]  drop_count;

   ltpi_data_channel_fifo_agent #(
      .REQ_WIDTH     (32),
      .RESP_WIDTH    (32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .host_req_valid   (host_req_valid),
      .host_req_data    (host_req_data),
      .host_req_ready   (host_req_ready),
      .host_resp_valid  (host_resp_valid),
      .host_resp_data   (host_resp_data),
      .host_resp_status (host_resp_status),
      .host_resp_ready  (host_resp_ready),
      .fifo_req_wr_en   (fifo_req_wr_en),
      .fifo_req_wr_data (fifo_req_wr_data),
      .fifo_req_wr_ack  (fifo_req_wr_ack),
      .fifo_req_full    (fifo_req_full),
      .fifo_resp_rd_en  (fifo_resp_rd_en),
      .fifo_resp_rd_data(fifo_resp_rd_data),
      .fifo_resp_rd_ack (fifo_resp_rd_ack),
      .fifo_resp_empty  (fifo_resp_empty),
      .busy             (busy),
      .drop_count       (drop_count)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_wr_q[$];
   logic [32:0] exp_resp_q[$];
   logic [31:0] fifo_q[$];
   logic [32:0] exp_e;

   bit          auto_en = 1'b0;
   int          auto_delay = 10;
   logic [31:0] auto_data = '0;
   bit          hold_rd = 1'b0;
   bit          pend_valid = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_data = '0;
   int          wr_strobes = 0;
   int          rd_strobes = 0;
   int          rel_cyc = 0;
   bit          overlap = 1'b0;
   bit          bad_strobe = 1'b0;
   logic        prev_wr = 1'b0;
   logic        prev_rd = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // FIFO model: acks one cycle after a strobe, releases after strobe drop
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (fifo_req_wr_en && fifo_resp_rd_en) overlap = 1'b1;
         if (fifo_req_wr_en && !prev_wr && fifo_req_wr_ack) bad_strobe = 1'b1;
         if (fifo_resp_rd_en && !prev_rd && fifo_resp_rd_ack) bad_strobe = 1'b1;
         prev_wr = fifo_req_wr_en;
         prev_rd = fifo_resp_rd_en;
         if (fifo_req_wr_en && !fifo_req_wr_ack) begin
            fifo_req_wr_ack = 1'b1;
            wr_strobes++;
            if (exp_wr_q.size() == 0) check("wr_unexpected", exp_wr_q.size(), 1);
            else check("wr_data", fifo_req_wr_data, exp_wr_q.pop_front());
            if (auto_en) begin
               pend_valid = 1'b1;
               pend_cnt   = auto_delay;
               pend_data  = auto_data;
            end
         end else if (!fifo_req_wr_en && fifo_req_wr_ack) begin
            fifo_req_wr_ack = 1'b0;
            rel_cyc = cyc;
         end
         if (pend_valid) begin
            if (pend_cnt == 0) begin
               fifo_q.push_back(pend_data);
               pend_valid = 1'b0;
            end else pend_cnt--;
         end
         if (fifo_resp_rd_en && !fifo_resp_rd_ack && !hold_rd && fifo_q.size() > 0) begin
            fifo_resp_rd_data = fifo_q.pop_front();
            fifo_resp_rd_ack  = 1'b1;
            rd_strobes++;
         end else if (!fifo_resp_rd_en && fifo_resp_rd_ack) begin
            fifo_resp_rd_ack = 1'b0;
         end
         fifo_resp_empty = (fifo_q.size() == 0);
      end
   end

   // Host response monitor: the handshake completes on the next rising edge
   always @(negedge clk) begin
      if (reset_n && host_resp_valid && host_resp_ready) begin
         if (exp_resp_q.size() == 0) check("resp_unexpected", exp_resp_q.size(), 1);
         else begin
            exp_e = exp_resp_q.pop_front();
            check("resp_data", host_resp_data, exp_e[31:0]);
            check("resp_status", host_resp_status, exp_e[32]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [31:0] d);
      bit ok = 1'b0;
      host_req_valid = 1'b1;
      host_req_data  = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (host_req_ready) begin
            ok = 1'b1;
            exp_wr_q.push_back(d);
            break;
         end
      end
      step();
      host_req_valid = 1'b0;
      check("req_accept", ok, 1);
   endtask

   task automatic wait_valid(output int c);
      bit ok = 1'b0;
      c = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (host_resp_valid) begin
            ok = 1'b1;
            c  = cyc;
            break;
         end
      end
      check("resp_valid_seen", ok, 1);
   endtask

   task automatic get_resp();
      int c;
      wait_valid(c);
      host_resp_ready = 1'b1;
      step();
      host_resp_ready = 1'b0;
   endtask

   initial begin
      int          c;
      int          m;
      bit          flag;
      bit          saw;
      logic [32:0] snap;

      // Reset state
      repeat (3) step();
      check("rst_ctrl", {host_req_ready, host_resp_valid, host_resp_status, fifo_req_wr_en,
                         fifo_resp_rd_en, busy, drop_count}, '0);
      check("rst_data", {host_resp_data, fifo_req_wr_data}, '0);
      reset_n = 1'b1;
      repeat (2) step();
      check("idle_ready", host_req_ready, 1);

      // 1: single transaction
      auto_en = 1'b1; auto_delay = 10; auto_data = 32'h0000_1234;
      exp_resp_q.push_back({1'b0, 32'h0000_1234});
      send_req(32'hA5A5_0001);
      get_resp();
      check("t1_valid_drop", host_resp_valid, 0);
      check("t1_busy", busy, 0);
      check("t1_wr_strobes", wr_strobes, 1);
      check("t1_rd_strobes", rd_strobes, 1);

      // 2: timeout
      auto_en = 1'b0;
      exp_resp_q.push_back({1'b1, 32'h0});
      send_req(32'h0000_0002);
      wait_valid(c);
      check("t2_latency", c - rel_cyc, 17);
      host_resp_ready = 1'b1;
      step();
      host_resp_ready = 1'b0;

      // 3: late response is flushed
      step();
      @(negedge clk);
      fifo_q.push_back(32'h0000_DEAD);
      flag = 1'b0; saw = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (fifo_resp_rd_en) saw = 1'b1;
         if (saw && drop_count == 0 && host_req_ready) flag = 1'b1;
         if (drop_count != 0) break;
      end
      check("t3_flush_seen", saw, 1);
      check("t3_ready_held", flag, 0);
      check("t3_drop", drop_count, 1);
      step();
      check("t3_ready_after", host_req_ready, 1);

      // 4: request FIFO backpressure
      fifo_req_full = 1'b1;
      repeat (2) step();
      host_req_valid = 1'b1;
      host_req_data  = 32'hC0DE_0004;
      flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (host_req_ready || fifo_req_wr_en) flag = 1'b1;
      end
      check("t4_blocked", flag, 0);
      auto_en = 1'b1; auto_delay = 3; auto_data = 32'hBEEF_0004;
      exp_resp_q.push_back({1'b0, 32'hBEEF_0004});
      fifo_req_full = 1'b0;
      m = cyc;
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (host_req_ready) begin
            saw = 1'b1;
            c   = cyc;
            exp_wr_q.push_back(32'hC0DE_0004);
            break;
         end
      end
      check("t4_ready_seen", saw, 1);
      check("t4_ready_delay", c - m, 1);
      step();
      host_req_valid = 1'b0;
      check("t4_wr_en", fifo_req_wr_en, 1);
      get_resp();

      // 5: host stall
      auto_data = 32'h55AA_0005;
      exp_resp_q.push_back({1'b0, 32'h55AA_0005});
      send_req(32'h0000_0005);
      wait_valid(c);
      snap = {host_resp_status, host_resp_data};
      m = wr_strobes + rd_strobes;
      flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!host_resp_valid || {host_resp_status, host_resp_data} != snap) flag = 1'b1;
         if (fifo_req_wr_en || fifo_resp_rd_en) flag = 1'b1;
      end
      check("t5_stable", flag, 0);
      check("t5_no_strobes", wr_strobes + rd_strobes, m);
      check("t5_snap", snap, {1'b0, 32'h55AA_0005});
      host_resp_ready = 1'b1;
      step();
      host_resp_ready = 1'b0;

      // 6: reset during response read, then drop_count saturation
      hold_rd = 1'b1;
      auto_data = 32'h0BAD_0006;
      send_req(32'h0000_0006);
      saw = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (fifo_resp_rd_en) begin
            saw = 1'b1;
            break;
         end
      end
      check("t6_rd_en_seen", saw, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_ctrl", {host_req_ready, host_resp_valid, host_resp_status, fifo_req_wr_en,
                            fifo_resp_rd_en, busy, drop_count}, '0);
      check("t6_rst_data", {host_resp_data, fifo_req_wr_data}, '0);
      repeat (3) step();
      reset_n = 1'b1;
      hold_rd = 1'b0;
      auto_en = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (drop_count != 0 && !busy) break;
      end
      check("t6_post_rst_drop", drop_count, 1);
      @(negedge clk);
      for (int i = 0; i < 299; i++) fifo_q.push_back(32'hF000_0000 + 32'(i));
      saw = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         step();
         if (fifo_q.size() == 0 && !fifo_resp_empty == 1'b0 && !busy && !fifo_resp_rd_ack) begin
            saw = 1'b1;
            break;
         end
      end
      check("t6_storm_done", saw, 1);
      repeat (3) step();
      check("t6_drop_sat", drop_count, 8'd255);

      check("no_overlap", overlap, 0);
      check("no_strobe_on_ack", bad_strobe, 0);
      check("wr_q_drained", exp_wr_q.size(), 0);
      check("resp_q_drained", exp_resp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
